// File: rtl/hero_write_arb.sv
// hero_write_arb: round-robin arbiter sharing one hero write bus between NUM_REQ sources.
// Whole multi-beat transactions (VALID run terminated by DONE) are granted atomically, and the
// bus is driven from a single registered output stage with downstream backpressure.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid         per-requester beat valid
//   req_cycle_type    per-requester cycle type (IDLE=0, VALID=1, DONE=2)
//   req_wdat          per-requester beat data
//   req_ready         per-requester accept (one-hot or zero)
//   hero_ready        downstream accepts the current output beat
//   hero_cycle_type   registered bus cycle type
//   hero_wdat         registered bus data
//   hero_clk_en       registered, 1 while the output stage holds a beat
//   grant_id          current or last granted requester
//   busy              1 while a transaction holds the lock
//   err_idle_beat     sticky flag for accepted IDLE / reserved-type beats
module hero_write_arb #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned HERO_WIDTH = 36
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ-1:0][1:0]            req_cycle_type,
    input  logic [NUM_REQ-1:0][HERO_WIDTH-1:0] req_wdat,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic                               hero_ready,
    output logic [1:0]                         hero_cycle_type,
    output logic [HERO_WIDTH-1:0]              hero_wdat,
    output logic                               hero_clk_en,
    output logic [$clog2(NUM_REQ)-1:0]         grant_id,
    output logic                               busy,
    output logic                               err_idle_beat
);

    localparam int unsigned PtrW    = $clog2(NUM_REQ);
    localparam logic [1:0]  CtIdle  = 2'd0;
    localparam logic [1:0]  CtValid = 2'd1;
    localparam logic [1:0]  CtDone  = 2'd2;

    typedef enum logic {StArb, StLock} state_e;

    state_e                  state_q;
    logic [PtrW-1:0]         rr_ptr_q;
    logic [PtrW-1:0]         grant_id_q;
    logic                    out_vld_q;
    logic [1:0]              out_type_q;
    logic [HERO_WIDTH-1:0]   out_data_q;
    logic                    err_q;

    logic                    slot_free;
    logic                    any_valid;
    logic [PtrW-1:0]         winner;
    logic [PtrW-1:0]         sel;
    logic [PtrW-1:0]         next_ptr;
    logic                    accept;
    logic [1:0]              beat_type;
    logic                    beat_ok;

    // First valid requester at or after rr_ptr, scanning upward with wrap.
    always_comb begin
        logic [PtrW:0] idx;
        idx       = '0;
        any_valid = 1'b0;
        winner    = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            idx = {1'b0, rr_ptr_q} + (PtrW+1)'(i);
            if (idx >= (PtrW+1)'(NUM_REQ)) begin
                idx = idx - (PtrW+1)'(NUM_REQ);
            end
            if (!any_valid && req_valid[idx[PtrW-1:0]]) begin
                any_valid = 1'b1;
                winner    = idx[PtrW-1:0];
            end
        end
    end

    assign slot_free = !out_vld_q || hero_ready;
    assign sel       = (state_q == StLock) ? grant_id_q : winner;
    assign next_ptr  = (sel == PtrW'(NUM_REQ - 1)) ? '0 : sel + PtrW'(1);

    always_comb begin
        req_ready = '0;
        if (state_q == StLock) begin
            req_ready[grant_id_q] = slot_free;
        end else if (any_valid) begin
            req_ready[winner] = slot_free;
        end
    end

    assign accept    = req_valid[sel] && req_ready[sel];
    assign beat_type = req_cycle_type[sel];
    assign beat_ok   = (beat_type == CtValid) || (beat_type == CtDone);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StArb;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            out_vld_q  <= 1'b0;
            out_type_q <= CtIdle;
            out_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            // Output stage: reload on accept (no bubble on drain), else clear once drained so
            // the bus reads IDLE/0 straight from the flops.
            if (accept && beat_ok) begin
                out_vld_q  <= 1'b1;
                out_type_q <= beat_type;
                out_data_q <= req_wdat[sel];
            end else if (hero_ready) begin
                out_vld_q  <= 1'b0;
                out_type_q <= CtIdle;
                out_data_q <= '0;
            end

            if (accept) begin
                if (!beat_ok) begin
                    // Malformed beat is swallowed; arbitration state is left untouched.
                    err_q <= 1'b1;
                end else begin
                    grant_id_q <= sel;
                    case (state_q)
                        StArb: begin
                            if (beat_type == CtValid) begin
                                state_q <= StLock;
                            end else begin
                                rr_ptr_q <= next_ptr;
                            end
                        end
                        StLock: begin
                            if (beat_type == CtDone) begin
                                state_q  <= StArb;
                                rr_ptr_q <= next_ptr;
                            end
                        end
                        default: state_q <= StArb;
                    endcase
                end
            end
        end
    end

    assign hero_cycle_type = out_type_q;
    assign hero_wdat       = out_data_q;
    assign hero_clk_en     = out_vld_q;
    assign grant_id        = grant_id_q;
    assign busy            = (state_q == StLock);
    assign err_idle_beat   = err_q;

endmodule

// File: tb/tb_hero_write_arb.sv
// tb_hero_write_arb: scoreboard bench for hero_write_arb (NUM_REQ=4, HERO_WIDTH=36).
// Each requester replays a list of beats; expected bus beats are queued when stimulus is
// loaded and popped as the bus hands beats downstream.
module tb_hero_write_arb;

    localparam int NR = 4;
    localparam int HW = 36;
    localparam logic [1:0] T_IDLE  = 2'd0;
    localparam logic [1:0] T_VALID = 2'd1;
    localparam logic [1:0] T_DONE  = 2'd2;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b1;
    logic [NR-1:0]              req_valid;
    logic [NR-1:0][1:0]         req_cycle_type;
    logic [NR-1:0][HW-1:0]      req_wdat;
    logic [NR-1:0]              req_ready;
    logic                       hero_ready;
    logic [1:0]                 hero_cycle_type;
    logic [HW-1:0]              hero_wdat;
    logic                       hero_clk_en;
    logic [1:0]                 grant_id;
    logic                       busy;
    logic                       err_idle_beat;

    hero_write_arb #(
        .NUM_REQ   (NR),
        .HERO_WIDTH(HW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_cycle_type (req_cycle_type),
        .req_wdat       (req_wdat),
        .req_ready      (req_ready),
        .hero_ready     (hero_ready),
        .hero_cycle_type(hero_cycle_type),
        .hero_wdat      (hero_wdat),
        .hero_clk_en    (hero_clk_en),
        .grant_id       (grant_id),
        .busy           (busy),
        .err_idle_beat  (err_idle_beat)
    );

    always #5 clk = ~clk;

    logic [HW+1:0] src_mem [NR][16];
    int            src_len [NR];
    int            src_pos [NR];
    logic [HW+1:0] exp_q [$];
    int            n_vec = 0;
    int            n_err = 0;
    logic [NR-1:0] rdy_s;
    logic          stall_prev = 1'b0;
    logic [HW+1:0] held;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [HW-1:0] mk(input int id, input int k);
        return HW'(id * 256 + k);
    endfunction

    task automatic load(input int id, input logic [1:0] ty, input logic [HW-1:0] d);
        src_mem[id][src_len[id]] = {ty, d};
        src_len[id]++;
    endtask

    task automatic expect_beat(input logic [1:0] ty, input logic [HW-1:0] d);
        exp_q.push_back({ty, d});
    endtask

    task automatic drive_srcs();
        for (int i = 0; i < NR; i++) begin
            if (src_pos[i] < src_len[i]) begin
                req_valid[i] = 1'b1;
                {req_cycle_type[i], req_wdat[i]} = src_mem[i][src_pos[i]];
            end else begin
                req_valid[i]      = 1'b0;
                req_cycle_type[i] = T_IDLE;
                req_wdat[i]       = '0;
            end
        end
    endtask

    function automatic bit srcs_done();
        for (int i = 0; i < NR; i++) begin
            if (src_pos[i] < src_len[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One clock: sample/score at negedge, then advance sources just after posedge.
    task automatic cycle();
        logic [NR-1:0] acc;
        logic [HW+1:0] e;
        logic [HW+1:0] cur;
        logic [1:0]    ty;
        bit            lat;
        lat = 1'b0;
        @(negedge clk);
        rdy_s = req_ready;
        acc   = req_valid & req_ready;
        cur   = {hero_cycle_type, hero_wdat};
        check_eq("ready_onehot", 64'($onehot0(req_ready)), 64'd1);
        if (stall_prev) check_eq("bp_hold", cur, held);
        stall_prev = 1'b0;
        if (hero_clk_en) begin
            if (hero_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_beat", 64'(hero_clk_en), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("beat", cur, e);
                end
            end else begin
                check_eq("bp_ready", req_ready, 0);
                held       = cur;
                stall_prev = 1'b1;
            end
        end else begin
            check_eq("idle_bus", cur, 0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) begin
                e  = src_mem[i][src_pos[i]];
                ty = e[HW+1:HW];
                if (ty == T_VALID || ty == T_DONE) lat = 1'b1;
                src_pos[i]++;
            end
        end
        drive_srcs();
        if (lat) check_eq("latency", 64'(hero_clk_en), 64'd1);
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while ((!srcs_done() || exp_q.size() != 0) && n < bound) begin
            cycle();
            n++;
        end
        if (n >= bound) check_eq("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < NR; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
        exp_q.delete();
        stall_prev = 1'b0;
        drive_srcs();
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        hero_ready = 1'b1;
        clear_srcs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        hero_ready = 1'b1;
        clear_srcs();

        // Reset with everything idle.
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_type",  hero_cycle_type, 0);
        check_eq("rst_wdat",  hero_wdat, 0);
        check_eq("rst_clken", 64'(hero_clk_en), 0);
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_busy",  64'(busy), 0);
        check_eq("rst_err",   64'(err_idle_beat), 0);
        check_eq("rst_grant", grant_id, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) cycle();
        check_eq("idle_after_rst", 64'(hero_clk_en), 0);

        // Single requester 2: VALID, VALID, DONE.
        load(2, T_VALID, 36'h1); expect_beat(T_VALID, 36'h1);
        load(2, T_VALID, 36'h2); expect_beat(T_VALID, 36'h2);
        load(2, T_DONE,  36'h3); expect_beat(T_DONE,  36'h3);
        drive_srcs();
        cycle();
        check_eq("t2_busy0",  64'(busy), 1);
        check_eq("t2_grant",  grant_id, 2);
        cycle();
        check_eq("t2_busy1",  64'(busy), 1);
        cycle();
        check_eq("t2_busy_end", 64'(busy), 0);
        drain(20);
        // rr_ptr now 3: requester 3 beats requester 0.
        load(0, T_DONE, mk(0, 1));
        load(3, T_DONE, mk(3, 1));
        expect_beat(T_DONE, mk(3, 1));
        expect_beat(T_DONE, mk(0, 1));
        drive_srcs();
        drain(20);

        // All four requesters with 2-beat transactions; requester 0 queues a second one.
        do_reset();
        for (int id = 0; id < NR; id++) begin
            load(id, T_VALID, mk(id, 0));
            load(id, T_DONE,  mk(id, 1));
            expect_beat(T_VALID, mk(id, 0));
            expect_beat(T_DONE,  mk(id, 1));
        end
        load(0, T_VALID, mk(0, 2));
        load(0, T_DONE,  mk(0, 3));
        expect_beat(T_VALID, mk(0, 2));
        expect_beat(T_DONE,  mk(0, 3));
        drive_srcs();
        for (int k = 0; k < 10; k++) begin
            cycle();
            check_eq("b2b_clken", 64'(hero_clk_en), 1);
        end
        drain(30);

        // Requester 1 locked while 0, 2, 3 wait.
        do_reset();
        load(1, T_VALID, mk(1, 0)); expect_beat(T_VALID, mk(1, 0));
        load(1, T_VALID, mk(1, 1)); expect_beat(T_VALID, mk(1, 1));
        load(1, T_DONE,  mk(1, 2)); expect_beat(T_DONE,  mk(1, 2));
        drive_srcs();
        cycle();
        load(0, T_DONE, mk(0, 5));
        load(2, T_DONE, mk(2, 5));
        load(3, T_DONE, mk(3, 5));
        expect_beat(T_DONE, mk(2, 5));
        expect_beat(T_DONE, mk(3, 5));
        expect_beat(T_DONE, mk(0, 5));
        drive_srcs();
        cycle();
        check_eq("lock_rdy0_a", 64'(rdy_s[0]), 0);
        cycle();
        check_eq("lock_rdy0_b", 64'(rdy_s[0]), 0);
        check_eq("lock_rdy1",   64'(rdy_s[1]), 1);
        drain(30);

        // Backpressure: hero_ready low 3 cycles mid-transaction.
        for (int k = 0; k < 3; k++) begin
            load(3, T_VALID, mk(3, 16 + k));
            expect_beat(T_VALID, mk(3, 16 + k));
        end
        load(3, T_DONE, mk(3, 19));
        expect_beat(T_DONE, mk(3, 19));
        drive_srcs();
        cycle();
        cycle();
        hero_ready = 1'b0;
        held = {hero_cycle_type, hero_wdat};
        begin
            logic [HW+1:0] snap;
            snap = held;
            repeat (3) begin
                cycle();
                check_eq("bp_stable", {hero_cycle_type, hero_wdat}, snap);
                check_eq("bp_all_rdy", rdy_s, 0);
            end
        end
        hero_ready = 1'b1;
        drain(30);

        // Reset while locked with a beat in the output stage.
        load(1, T_VALID, mk(1, 32));
        load(1, T_VALID, mk(1, 33));
        load(1, T_DONE,  mk(1, 34));
        drive_srcs();
        cycle();
        rst_n = 1'b0;
        #1;
        check_eq("arst_clken", 64'(hero_clk_en), 0);
        check_eq("arst_busy",  64'(busy), 0);
        clear_srcs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        load(3, T_DONE, mk(3, 48));
        expect_beat(T_DONE, mk(3, 48));
        drive_srcs();
        drain(20);
        check_eq("arst_grant3", grant_id, 3);

        // IDLE beat from requester 0 is swallowed and flagged.
        load(0, T_IDLE, mk(0, 64));
        drive_srcs();
        cycle();
        check_eq("idle_beat_bus", 64'(hero_clk_en), 0);
        check_eq("idle_beat_err", 64'(err_idle_beat), 1);
        load(1, T_DONE, mk(1, 65));
        expect_beat(T_DONE, mk(1, 65));
        drive_srcs();
        drain(20);
        check_eq("err_sticky", 64'(err_idle_beat), 1);
        do_reset();
        check_eq("err_cleared", 64'(err_idle_beat), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
